// File: rtl/equiv_stim_sequencer_if.sv
// equiv_stim_sequencer_if: control, DUT-output and stimulus/result bundle for the equivalence sequencer.
interface equiv_stim_sequencer_if;
    logic start;
    logic abort;
    logic [90:0] y_1;
    logic [90:0] y_2;
    logic signed [25:0] wire0;
    logic signed [24:0] wire1;
    logic [14:0] wire2;
    logic signed [5:0] wire3;
    logic busy;
    logic done;
    logic pass;
    logic [15:0] mismatch_count;
    logic first_fail_valid;
    logic [15:0] first_fail_idx;
    modport master (
        output start, abort, y_1, y_2,
        input wire0, wire1, wire2, wire3, busy, done, pass, mismatch_count, first_fail_valid, first_fail_idx
    );
    modport slave (
        input start, abort, y_1, y_2,
        output wire0, wire1, wire2, wire3, busy, done, pass, mismatch_count, first_fail_valid, first_fail_idx
    );
endinterface

// File: rtl/equiv_stim_sequencer.sv
// equiv_stim_sequencer: drives a shared LFSR stimulus into two DUTs and compares their outputs after LATENCY cycles.
// Define EQSEQ_STOP_ON_FAIL_EN to end the run on the first mismatch.
module equiv_stim_sequencer #(
    parameter int NUM_VECTORS = 256,
    parameter int LATENCY = 0,
    parameter logic [31:0] SEED = 32'hACE12024
) (
    input logic clk,
    input logic rst_n,
    equiv_stim_sequencer_if.slave bus
);
    localparam logic [31:0] SEED_NZ = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [16:0] LAST_ISSUE = 17'(NUM_VECTORS);
    localparam logic [16:0] LAST_CYC = 17'(NUM_VECTORS + LATENCY);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state;
    logic [31:0] lfsr;
    logic [31:0] cur;
    logic [16:0] vec_idx;
    logic [LATENCY:0] vld_p;
    logic [LATENCY:0][15:0] idx_p;
    logic [71:0] stim;
    logic [15:0] cnt_nxt;
    logic active, go, abort_act, mis, stop, issue;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
    endfunction

    assign active = state == RUN || state == DRAIN;
    assign go = !active && bus.start && !bus.abort;
    assign abort_act = active && bus.abort;
    assign mis = vld_p[LATENCY] && bus.y_1 != bus.y_2 && !abort_act;
`ifdef EQSEQ_STOP_ON_FAIL_EN
    assign stop = mis;
`else
    assign stop = 1'b0;
`endif
    // vec_idx keeps counting through DRAIN so one counter times the whole run
    assign issue = go || (state == RUN && vec_idx < LAST_ISSUE && !abort_act && !stop);
    assign cur = go ? SEED_NZ : lfsr;
    assign stim = {cur, cur[15:0], cur[31:16], go ? 8'd0 : vec_idx[7:0]};
    assign cnt_nxt = go ? 16'd0 : bus.mismatch_count + 16'(mis && bus.mismatch_count != 16'hFFFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            lfsr <= SEED_NZ;
            vec_idx <= '0;
            vld_p <= '0;
            idx_p <= '0;
            bus.wire0 <= '0;
            bus.wire1 <= '0;
            bus.wire2 <= '0;
            bus.wire3 <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.pass <= 1'b0;
            bus.mismatch_count <= '0;
            bus.first_fail_valid <= 1'b0;
            bus.first_fail_idx <= '0;
        end else begin
            if (abort_act) begin
                state <= IDLE;
                bus.busy <= 1'b0;
            end else if (go) begin
                state <= RUN;
                bus.busy <= 1'b1;
                bus.done <= 1'b0;
                bus.pass <= 1'b0;
            end else if (active && (stop || vec_idx == LAST_CYC)) begin
                state <= DONE;
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
                bus.pass <= cnt_nxt == 16'd0;
            end else if (state == RUN && vec_idx == LAST_ISSUE) begin
                state <= DRAIN;
            end
            if (go || active) vec_idx <= go ? 17'd1 : vec_idx + 17'd1;
            if (issue) begin
                lfsr <= lfsr_step(cur);
                bus.wire0 <= stim[71:46];
                bus.wire1 <= stim[45:21];
                bus.wire2 <= stim[20:6];
                bus.wire3 <= stim[5:0];
            end
            vld_p[0] <= issue;
            idx_p[0] <= go ? 16'd0 : vec_idx[15:0];
            for (int i = 1; i <= LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1] && !abort_act && !stop;
                idx_p[i] <= idx_p[i-1];
            end
            bus.mismatch_count <= cnt_nxt;
            if (go) begin
                bus.first_fail_valid <= 1'b0;
                bus.first_fail_idx <= '0;
            end else if (mis && !bus.first_fail_valid) begin
                bus.first_fail_valid <= 1'b1;
                bus.first_fail_idx <= idx_p[LATENCY];
            end
        end
    end
endmodule
